// File: rtl/lsu.sv
// Load/store unit: turns a byte/half/word access into one or two aligned bus
// beats, realigning store data and extending load data.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        memrw,
  input  logic [1:0]  memword,
  input  logic        memsign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;

  state_t      state_q, state_d;
  logic        rw_q;
  logic [1:0]  word_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] r0_q;
  logic [31:0] rdata_q, rdata_d;
  logic        load_ops;
  logic        r0_we;

  logic [7:0]  lanes;
  logic [63:0] store_sh;
  logic [31:0] beat0_addr;

  // Byte lanes touched across the two-word window starting at the aligned address.
  function automatic logic [7:0] lane_vec(input logic [1:0] word, input logic [1:0] off);
    logic [7:0] m;
    case (word)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] ext_load(input logic [63:0] r, input logic [1:0] word,
                                           input logic zext, input logic [1:0] off);
    logic [63:0] sh;
    sh = r >> {off, 3'b000};
    case (word)
      2'b00:   return zext ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return zext ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh[31:0];
    endcase
  endfunction

  assign lanes      = lane_vec(word_q, addr_q[1:0]);
  assign store_sh   = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign beat0_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    load_ops = 1'b0;
    r0_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_ops = 1'b1;
          if (memword == 2'b11) begin
            state_d = FIN;
            rdata_d = 32'b0;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (bus_ack) begin
          if (lanes[7:4] != 4'b0) begin
            r0_we   = 1'b1;
            state_d = BEAT1;
          end else begin
            state_d = FIN;
            if (!rw_q) rdata_d = ext_load({32'b0, bus_rdata}, word_q, sign_q, addr_q[1:0]);
          end
        end
      end
      BEAT1: begin
        if (bus_ack) begin
          state_d = FIN;
          if (!rw_q) rdata_d = ext_load({bus_rdata, r0_q}, word_q, sign_q, addr_q[1:0]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode only registered state, so bus_ack never reaches them.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'b0;
    bus_be    = 4'b0;
    bus_wdata = 32'b0;
    case (state_q)
      BEAT0: begin
        bus_req   = 1'b1;
        bus_we    = rw_q;
        bus_addr  = beat0_addr;
        bus_be    = lanes[3:0];
        bus_wdata = store_sh[31:0];
      end
      BEAT1: begin
        bus_req   = 1'b1;
        bus_we    = rw_q;
        bus_addr  = beat0_addr + 32'd4;
        bus_be    = lanes[7:4];
        bus_wdata = store_sh[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      word_q  <= 2'b0;
      sign_q  <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      r0_q    <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (load_ops) begin
        rw_q    <= memrw;
        word_q  <= memword;
        sign_q  <= memsign;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= (memword == 2'b11);
      end
      if (r0_we) r0_q <= bus_rdata;
    end
  end

  assign rdata = rdata_q;
  assign done  = (state_q == FIN);
  assign err   = done && err_q;
  assign busy  = (state_q != IDLE) || start;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, word-crossing, wrap, wait states,
// reserved size and mid-access reset.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, memrw, memsign, bus_ack;
  logic [1:0]  memword;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        done, busy, err, bus_req, bus_we;
  logic [3:0]  bus_be;
  int total = 0;
  int bad   = 0;

  lsu dut (
    .clk(clk), .rst(rst), .start(start), .memrw(memrw), .memword(memword),
    .memsign(memsign), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
    .busy(busy), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rw, input logic [1:0] w, input logic s,
                     input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; memrw = rw; memword = w; memsign = s; addr = a; wdata = d;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; memrw = 1'b0; memword = 2'b0; memsign = 1'b0;
    addr = 32'b0; wdata = 32'b0; bus_ack = 1'b0; bus_rdata = 32'b0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    step();

    // SW 0x100, zero wait
    req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    bus_ack = 1'b1;
    #1 chk("sw_busy_c0", {31'b0, busy}, 32'd1);
    step();
    chk("sw_req", {31'b0, bus_req}, 32'd1);
    chk("sw_we", {31'b0, bus_we}, 32'd1);
    chk("sw_addr", bus_addr, 32'h100);
    chk("sw_be", {28'b0, bus_be}, 32'hF);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    chk("sw_done_c1", {31'b0, done}, 32'd0);
    step();
    chk("sw_done_c2", {31'b0, done}, 32'd1);
    chk("sw_busy_c2", {31'b0, busy}, 32'd1);
    chk("sw_req_c2", {31'b0, bus_req}, 32'd0);
    start = 1'b0; bus_ack = 1'b0;
    step();
    chk("sw_done_c3", {31'b0, done}, 32'd0);
    chk("sw_busy_c3", {31'b0, busy}, 32'd0);

    // LB 0x103 sign-extended, then zero-extended
    for (int k = 0; k < 2; k++) begin
      req(1'b0, 2'b00, k[0], 32'h103, 32'h0);
      bus_ack = 1'b1; bus_rdata = 32'h80FFFFFF;
      step();
      chk("lb_we", {31'b0, bus_we}, 32'd0);
      chk("lb_addr", bus_addr, 32'h100);
      chk("lb_be", {28'b0, bus_be}, 32'h8);
      step();
      chk("lb_done", {31'b0, done}, 32'd1);
      chk(k == 0 ? "lb_rdata_sx" : "lb_rdata_zx", rdata, k == 0 ? 32'hFFFFFF80 : 32'h00000080);
      start = 1'b0; bus_ack = 1'b0;
      step();
    end

    // SH 0x203 crossing
    req(1'b1, 2'b01, 1'b0, 32'h203, 32'h0000ABCD);
    bus_ack = 1'b1;
    step();
    chk("sh_b0_addr", bus_addr, 32'h200);
    chk("sh_b0_be", {28'b0, bus_be}, 32'h8);
    chk("sh_b0_lane3", {24'b0, bus_wdata[31:24]}, 32'hCD);
    step();
    chk("sh_b1_addr", bus_addr, 32'h204);
    chk("sh_b1_be", {28'b0, bus_be}, 32'h1);
    chk("sh_b1_lane0", {24'b0, bus_wdata[7:0]}, 32'hAB);
    chk("sh_b1_done", {31'b0, done}, 32'd0);
    step();
    chk("sh_done", {31'b0, done}, 32'd1);
    start = 1'b0; bus_ack = 1'b0;
    step();

    // LW 0xFFFFFFFE crossing with wrap and 3 wait states on beat0
    req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
    step();
    chk("lw_b0_addr", bus_addr, 32'hFFFFFFFC);
    chk("lw_b0_be", {28'b0, bus_be}, 32'hC);
    step();
    step();
    chk("lw_wait_req", {31'b0, bus_req}, 32'd1);
    chk("lw_wait_addr", bus_addr, 32'hFFFFFFFC);
    chk("lw_wait_done", {31'b0, done}, 32'd0);
    step();
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    step();
    chk("lw_b1_addr", bus_addr, 32'h00000000);
    chk("lw_b1_be", {28'b0, bus_be}, 32'h3);
    bus_rdata = 32'h55667788;
    step();
    chk("lw_done", {31'b0, done}, 32'd1);
    chk("lw_rdata", rdata, 32'h77881122);
    start = 1'b0; bus_ack = 1'b0;
    step();
    chk("lw_rdata_hold", rdata, 32'h77881122);

    // Reserved size
    req(1'b0, 2'b11, 1'b0, 32'h400, 32'h0);
    step();
    chk("rsv_req", {31'b0, bus_req}, 32'd0);
    chk("rsv_done", {31'b0, done}, 32'd1);
    chk("rsv_err", {31'b0, err}, 32'd1);
    chk("rsv_rdata", rdata, 32'd0);
    start = 1'b0;
    step();
    chk("rsv_err_end", {31'b0, err}, 32'd0);

    // Reset while beat0 waits for ack
    req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    step();
    chk("rr_req_pre", {31'b0, bus_req}, 32'd1);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rr_req", {31'b0, bus_req}, 32'd0);
    chk("rr_busy", {31'b0, busy}, 32'd0);
    chk("rr_done", {31'b0, done}, 32'd0);
    step();
    rst = 1'b0;
    chk("rr_done2", {31'b0, done}, 32'd0);
    step();

    // Byte store after reset
    req(1'b1, 2'b00, 1'b0, 32'h106, 32'h12345678);
    bus_ack = 1'b1;
    step();
    chk("sb_addr", bus_addr, 32'h104);
    chk("sb_be", {28'b0, bus_be}, 32'h4);
    chk("sb_lane2", {24'b0, bus_wdata[23:16]}, 32'h78);
    step();
    chk("sb_done", {31'b0, done}, 32'd1);
    start = 1'b0; bus_ack = 1'b0;
    step();

    // LHU 0x102, aligned inside the word
    req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h9ABC0000;
    step();
    chk("lhu_be", {28'b0, bus_be}, 32'hC);
    step();
    chk("lhu_rdata", rdata, 32'h00009ABC);
    start = 1'b0; bus_ack = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
